// File: rtl/packet_serial_rx.sv
// rtl/packet_serial_rx.sv - receiver for multi-byte 8N1 packets with stop-bit and inter-byte timeout checks
module packet_serial_rx #(
  parameter int CLK_PER_BIT  = 54166,
  parameter int PKT_LENGTH   = 288,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic [PKT_LENGTH-1:0] data,
  output logic                  new_data,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  timeout_err
);

  localparam int NBYTES  = PKT_LENGTH / 8;
  localparam int TMO_CYC = TIMEOUT_BITS * CLK_PER_BIT;
  localparam int CW      = $clog2(TMO_CYC + 1);
  localparam int IW      = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [CW-1:0] HALF_M1  = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1   = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] TMO_M1   = CW'(TMO_CYC - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_GAP, S_FWAIT
  } state_t;

  state_t                state_q, state_d;
  logic                  meta_q, rxs_q, rxs_prev_q;
  logic [1:0]            arm_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         tmo_q, tmo_d;
  logic [2:0]            bit_q, bit_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  from_gap_q, from_gap_d;
  logic [PKT_LENGTH-1:0] shadow_q, shadow_d;
  logic [PKT_LENGTH-1:0] data_q, data_d;
  logic                  new_data_q, new_data_d;
  logic                  frame_err_q, frame_err_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  fall;
  logic                  hit_half, hit_bit, hit_tmo;

  // arm_q keeps the reset-preset synchronizer value from faking a falling edge
  // when the line is already low at reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q     <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      arm_q      <= 2'd0;
    end else begin
      meta_q     <= rx;
      rxs_q      <= meta_q;
      rxs_prev_q <= rxs_q;
      if (arm_q != 2'd3) arm_q <= arm_q + 2'd1;
    end
  end

  assign fall     = (arm_q == 2'd3) && rxs_prev_q && !rxs_q;
  assign hit_half = (cnt_q == HALF_M1);
  assign hit_bit  = (cnt_q == BIT_M1);
  assign hit_tmo  = (tmo_q == TMO_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fall) state_d = S_START;
      S_START: if (hit_half) begin
                 if (!rxs_q)          state_d = S_DATA;
                 else if (from_gap_q) state_d = S_GAP;
                 else                 state_d = S_IDLE;
               end
      S_DATA:  if (hit_bit && bit_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (hit_bit) begin
                 if (!rxs_q)                state_d = S_FWAIT;
                 else if (idx_q == LAST_IDX) state_d = S_IDLE;
                 else                       state_d = S_GAP;
               end
      S_GAP:   if (fall)         state_d = S_START;
               else if (hit_tmo) state_d = S_IDLE;
      S_FWAIT: if (rxs_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    bit_d         = bit_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    from_gap_d    = from_gap_q;
    shadow_d      = shadow_q;
    data_d        = data_q;
    new_data_d    = 1'b0;
    frame_err_d   = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      S_IDLE: if (fall) begin
        cnt_d      = '0;
        tmo_d      = '0;
        idx_d      = '0;
        from_gap_d = 1'b0;
      end
      S_START: begin
        cnt_d = hit_half ? '0 : cnt_q + CW'(1);
        if (hit_half) bit_d = 3'd0;
      end
      S_DATA: begin
        cnt_d = hit_bit ? '0 : cnt_q + CW'(1);
        if (hit_bit) begin
          shift_d = {rxs_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        cnt_d = hit_bit ? '0 : cnt_q + CW'(1);
        if (hit_bit) begin
          if (!rxs_q) begin
            frame_err_d = 1'b1;
            idx_d       = '0;
            shadow_d    = '0;
          end else if (idx_q == LAST_IDX) begin
            data_d       = shadow_q;
            data_d[7:0]  = shift_q;
            new_data_d   = 1'b1;
            idx_d        = '0;
          end else begin
            for (int b = 0; b < NBYTES; b++)
              if (idx_q == IW'(NBYTES - 1 - b)) shadow_d[8*b +: 8] = shift_q;
            idx_d = idx_q + IW'(1);
            tmo_d = '0;
          end
        end
      end
      // The timeout count is frozen while a glitch is being qualified in START.
      S_GAP: begin
        if (fall) begin
          cnt_d      = '0;
          from_gap_d = 1'b1;
        end else if (hit_tmo) begin
          timeout_err_d = 1'b1;
          idx_d         = '0;
          shadow_d      = '0;
          tmo_d         = '0;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      tmo_q         <= '0;
      bit_q         <= 3'd0;
      idx_q         <= '0;
      shift_q       <= 8'd0;
      from_gap_q    <= 1'b0;
      shadow_q      <= '0;
      data_q        <= '0;
      new_data_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      bit_q         <= bit_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      from_gap_q    <= from_gap_d;
      shadow_q      <= shadow_d;
      data_q        <= data_d;
      new_data_q    <= new_data_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign data        = data_q;
  assign new_data    = new_data_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q == S_START) || (state_q == S_DATA) ||
                       (state_q == S_STOP)  || (state_q == S_GAP);

endmodule

// File: tb/tb_packet_serial_rx.sv
// tb/tb_packet_serial_rx.sv - scoreboard bench for packet_serial_rx with a byte-level packet model
module tb_packet_serial_rx;

  localparam int CPB = 16;
  localparam int PKT = 16;
  localparam int TMO = 4;

  localparam int K_DATA = 0;
  localparam int K_FERR = 1;
  localparam int K_TMO  = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rx = 1'b1;
  logic [PKT-1:0] data;
  logic           new_data, busy, frame_err, timeout_err;

  packet_serial_rx #(.CLK_PER_BIT(CPB), .PKT_LENGTH(PKT), .TIMEOUT_BITS(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data(data), .new_data(new_data),
    .busy(busy), .frame_err(frame_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        kind;
    logic [15:0] d;
    int        lo;
    int        hi;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t_ref = 0;
  int          mcnt = 0;
  logic [15:0] mpkt = '0;
  logic [15:0] last_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push(input int k, input logic [15:0] d);
    exp_t e;
    e.kind = k;
    e.d    = d;
    // Pulses land half a bit into the stop bit plus synchronizer and register delay;
    // a timeout lands TMO bit-times after the stop-bit sample.
    e.lo   = (k == K_TMO) ? CPB / 2 + 1 + TMO * CPB : CPB / 2 + 2;
    e.hi   = (k == K_TMO) ? CPB / 2 + 5 + TMO * CPB : CPB / 2 + 4;
    q.push_back(e);
  endfunction

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    if (mcnt > 0 && n > TMO) begin
      push(K_TMO, '0);
      mcnt = 0;
    end
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    t_ref = cyc;
    if (!ok) begin
      push(K_FERR, '0);
      mcnt = 0;
    end else begin
      mpkt = {mpkt[7:0], b};
      mcnt++;
      if (mcnt == PKT / 8) begin
        push(K_DATA, mpkt);
        mcnt = 0;
      end
    end
    send_bit(ok);
  endtask

  task automatic glitch();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (CPB - 5) @(negedge clk);
  endtask

  exp_t m_e;
  int   m_kind;
  int   m_lat;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_data = '0;
    end else begin
      if (new_data || frame_err || timeout_err) begin
        chk("pulse_onehot", $countones({new_data, frame_err, timeout_err}), 1);
        m_kind = new_data ? K_DATA : (frame_err ? K_FERR : K_TMO);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got kind %0d expected none", m_kind);
        end else begin
          m_e = q.pop_front();
          chk("pulse_kind", m_kind, m_e.kind);
          m_lat = cyc - t_ref;
          checks++;
          if (m_lat < m_e.lo || m_lat > m_e.hi) begin
            errors++;
            $display("FAIL pulse_latency: got %0d expected %0d..%0d", m_lat, m_e.lo, m_e.hi);
          end
          if (m_kind == K_DATA) begin
            chk("data", data, m_e.d);
            chk("busy_at_done", busy, 0);
            last_data = m_e.d;
          end
        end
      end
      if (!new_data) chk("data_hold", data, last_data);
    end
  end

  initial begin
    int r;
    repeat (3) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_pulses", {new_data, frame_err, timeout_err}, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    idle_bits(2);

    send_byte(8'hA5, 1'b1); idle_bits(1); send_byte(8'h3C, 1'b1); idle_bits(2);
    chk("busy_after_pkt", busy, 0);

    glitch(); idle_bits(2);
    chk("busy_after_glitch", busy, 0);

    send_byte(8'hFF, 1'b0); idle_bits(2);
    send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1); idle_bits(2);

    send_byte(8'h55, 1'b1); idle_bits(5);
    chk("busy_after_tmo", busy, 0);

    send_byte(8'h77, 1'b1); idle_bits(1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    rst_n = 1'b0;
    rx = 1'b1;
    mcnt = 0;
    #1;
    chk("midrst_data", data, 0);
    chk("midrst_outs", {new_data, busy, frame_err, timeout_err}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(2);
    send_byte(8'hBE, 1'b1); send_byte(8'hEF, 1'b1); idle_bits(2);

    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h80, 1'b1); send_byte(8'h00, 1'b1); idle_bits(2);

    rst_n = 1'b0;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("low_at_release_busy", busy, 0);
    idle_bits(2);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        glitch();
      end else if (r == 1) begin
        if ($urandom_range(0, 1) == 1) send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b0);
      end else if (r == 2) begin
        send_byte(8'($urandom), 1'b1);
        idle_bits($urandom_range(TMO + 1, TMO + 2));
      end else begin
        send_byte(8'($urandom), 1'b1);
        idle_bits($urandom_range(0, 2));
        if (r == 3) glitch();
        send_byte(8'($urandom), 1'b1);
      end
      idle_bits($urandom_range(1, 3));
    end

    for (int i = 0; i < 2000 && q.size() > 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("busy_end", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_serial_rx.md
PACKET_SERIAL_RX -- requirements
Module: packet_serial_rx

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 54166: clock cycles per bit (1200 baud at 65 MHz); legal values are >= 8.
REQ-002 SHALL have parameter PKT_LENGTH, default 288 (32*9): packet width in bits; legal values are multiples of 8 and >= 8.
REQ-003 SHALL have parameter TIMEOUT_BITS, default 20: maximum idle bit-times allowed between bytes of one packet.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port rx, input, 1 bit: photodiode line, asynchronous to clk; idle level is 1.
REQ-007 SHALL have port data, output, PKT_LENGTH bits: last complete received packet.
REQ-008 SHALL have port new_data, output, 1 bit: one-cycle pulse when data has been updated.
REQ-009 SHALL have port busy, output, 1 bit: high while a packet is in progress.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port timeout_err, output, 1 bit: one-cycle pulse on an inter-byte timeout.

Function
REQ-012 SHALL be the receiving end of the packet_serial_tx line format: PKT_LENGTH/8 bytes, each sent 8N1 (start bit 0, 8 data bits LSB first, stop bit 1); byte 0 carries data[PKT_LENGTH-1:PKT_LENGTH-8] and is sent first.
REQ-013 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value (rxs).
REQ-014 SHALL implement the states IDLE, START, DATA, STOP and GAP.
REQ-015 IDLE: a falling edge of rxs SHALL move the block to START, clear the bit-period counter, and set byte_idx=0.
REQ-016 START: at count CLK_PER_BIT/2-1 (integer division), if rxs=0 the block SHALL restart the counter and go to DATA; if rxs=1 it is a glitch and the block SHALL return to the state it came from (IDLE, or GAP with the timeout count preserved).
REQ-017 DATA: the block SHALL sample rxs every CLK_PER_BIT cycles, shifting bits into an 8-bit register LSB first; after the 8th sample it SHALL go to STOP.
REQ-018 STOP: CLK_PER_BIT cycles after the 8th data sample, the block SHALL check rxs. If 1, it writes the byte into the shadow packet register at byte_idx. If 0, it pulses frame_err, discards the partial packet, and returns to IDLE only after rxs=1 is seen.
REQ-019 After a good stop bit on the last byte (byte_idx=PKT_LENGTH/8-1), the block SHALL copy the shadow register to data on the next cycle, pulse new_data in that same cycle, and go to IDLE.
REQ-020 After a good stop bit on any other byte, the block SHALL increment byte_idx and go to GAP.
REQ-021 GAP: a falling edge of rxs SHALL move the block to START. If TIMEOUT_BITS*CLK_PER_BIT cycles elapse without one, the block SHALL pulse timeout_err, discard the partial packet, and go to IDLE.
REQ-022 data SHALL change only in the new_data cycle and SHALL hold its value otherwise, including after errors.
REQ-023 busy SHALL be 1 in START, DATA, STOP and GAP, and 0 in IDLE and while waiting for line-high after a frame error.
REQ-024 Counters SHALL be sized to hold TIMEOUT_BITS*CLK_PER_BIT without overflow; no counter may wrap during a legal packet.
REQ-025 new_data, frame_err and timeout_err SHALL be mutually exclusive in any cycle.
REQ-026 Latency: new_data SHALL occur 1 cycle after the stop-bit sample of the last byte, plus 2 cycles of synchronizer delay relative to rx.

Reset
REQ-027 While rst_n=0 the block SHALL be in IDLE with data=0, new_data=0, busy=0, frame_err=0, timeout_err=0, byte_idx=0, all counters 0, and the synchronizer flops set to 1.
REQ-028 Assertion of rst_n mid-packet SHALL abort the packet immediately with no error pulse. After release, the block SHALL wait for a fresh falling edge; a line already low at release SHALL NOT start reception until it returns high and falls again.

Verification (CLK_PER_BIT=16, PKT_LENGTH=16, TIMEOUT_BITS=4)
REQ-029 Send bytes 0xA5 then 0x3C with a 1-bit gap -> a single new_data pulse, data=16'hA53C, busy=0 afterwards, no error pulses.
REQ-030 Pull rx low for 5 cycles in IDLE -> no state change beyond START, busy drops back to 0, no pulses, data unchanged.
REQ-031 Send 0xFF with stop bit 0 -> one frame_err pulse, no new_data; then send a good 2-byte packet 0x1234 -> data=16'h1234.
REQ-032 Send byte 0x55 then hold the line idle for 5 bit-times -> one timeout_err pulse after 64 cycles in GAP, and data keeps its previous value.
REQ-033 Pulse rst_n low during the 2nd byte -> all outputs return to 0 immediately; a following good packet 0xBEEF -> data=16'hBEEF.
REQ-034 Send two packets back-to-back with the minimum 1-stop-bit spacing (0x0001, then 0x8000) -> two new_data pulses with correct data each time.
